adder_share_ctrl: RTL
=====================

Name: adder_share_ctrl

Overview:
- Round-robin controller that shares one external combinational N-bit adder among REQ requesters.
- Captures each request's operands, drives the adder for one cycle, and registers sum, carry and signed overflow.
- Returns the result on a single response channel tagged with the requester ID.
- Keeps a per-requester carry register, so a requester can build multi-word additions from chained transactions.
- Works with any adder in the family that has the a/b/cin to sum/cout shape.

Parameters:
- N, 32, operand and sum width
- REQ, 4, number of requesters
- ID_W, 2, width of requester ID; clog2(REQ), minimum 1

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  REQ  per-requester request valid
- req_ready  output  REQ  per-requester accept, one-hot or zero
- req_a  input  REQ*N  operand A; requester i in bits [i*N +: N]
- req_b  input  REQ*N  operand B, same packing as req_a
- req_cin  input  REQ  explicit carry-in
- req_chain  input  REQ  1 = use the stored carry of this requester instead of req_cin
- add_a  output  N  to shared adder in1
- add_b  output  N  to shared adder in2
- add_cin  output  1  to shared adder cin
- add_sum  input  N  from shared adder sum
- add_cout  input  1  from shared adder cout
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  ID_W  requester index of the response
- rsp_sum  output  N  registered sum
- rsp_cout  output  1  registered carry-out
- rsp_of  output  1  registered signed overflow
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n low) forces every register to 0:
  - state = IDLE, rr pointer = 0, carry_q[REQ-1:0] = 0;
  - rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_of = 0;
  - add_a, add_b, add_cin = 0; busy = 0.
  - req_ready is combinational and is 0 outside IDLE.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from index rr upward with wrap-around.
  - req_ready[g]=1 for the granted requester only, in the same cycle.
  - On the edge: capture a, b and effective cin, where effective cin = req_chain[g] ? carry_q[g] : req_cin[g].
  - Also capture id=g, set rr=(g+1) mod REQ, and go to EXEC.
  - With no valid requests: stay in IDLE; rr is unchanged.
- EXEC (exactly 1 cycle):
  - add_a, add_b and add_cin are driven from the captured registers. They hold their last values outside EXEC, which avoids toggling.
  - On the edge: rsp_sum=add_sum, rsp_cout=add_cout, rsp_of=(a[N-1]==b[N-1]) && (add_sum[N-1]!=a[N-1]), carry_q[id]=add_cout, rsp_valid=1, then go to RESP.
- RESP:
  - Hold all rsp_* fields stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE. The next grant happens in that IDLE cycle at the earliest.
- Latency and throughput:
  - Accept at edge T; rsp_valid rises at edge T+1 (visible in cycle T+2).
  - Peak throughput is one transaction every 3 cycles when rsp_ready is held at 1.
- Fairness: round-robin; a continuously requesting requester waits at most REQ-1 grants.
- Requests seen outside IDLE get req_ready=0. Requesters must hold req_valid and operands until accepted.
- carry_q[i] changes only when requester i's transaction completes EXEC; other requesters' carries are untouched.
- Width rule: sum is modulo 2^N. rsp_cout is the unsigned carry; rsp_of is the two's-complement overflow.
- Reset mid-operation (EXEC or RESP) drops the transaction and returns to IDLE with all state cleared. There is no partial response.

Test Plan:
- Single op: r0 a=0x0000_0005 b=0x0000_0003 cin=0 -> rsp_sum=0x8, cout=0, of=0, id=0, rsp_valid 2 cycles after accept.
- Overflow/carry: r1 a=0x7FFF_FFFF b=0x1 -> sum=0x8000_0000, of=1, cout=0; then a=0xFFFF_FFFF b=0x1 -> sum=0, cout=1, of=0.
- Chained 64-bit add: r2 low a=0xFFFF_FFFF b=0x1 cin=0, then high a=0x0 b=0x0 chain=1 -> high sum=0x1. Repeat the high word with chain=0, cin=0 -> sum=0x0.
- Round-robin: all four requesters valid continuously from reset -> grant order 0,1,2,3,0. Drop r1 -> order 2,3,0,2.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, no req_ready asserted, busy=1. Release -> next grant in the following cycle.
- Reset in RESP: assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 and carry_q=0 immediately. After release, a chain=1 op a=0 b=0 gives sum=0.

Source files
------------

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one external combinational adder among REQ requesters.
// Each transaction: accept in IDLE, drive the adder in EXEC, hold the tagged result in RESP.
module adder_share_ctrl #(
  parameter int unsigned N    = 32,
  parameter int unsigned REQ  = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQ-1:0]    req_valid,
  output logic [REQ-1:0]    req_ready,
  input  logic [REQ*N-1:0]  req_a,
  input  logic [REQ*N-1:0]  req_b,
  input  logic [REQ-1:0]    req_cin,
  input  logic [REQ-1:0]    req_chain,
  output logic [N-1:0]      add_a,
  output logic [N-1:0]      add_b,
  output logic              add_cin,
  input  logic [N-1:0]      add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_of,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   id_q;
  logic [REQ-1:0]    carry_q;
  logic [N-1:0]      a_q;
  logic [N-1:0]      b_q;
  logic              cin_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [N-1:0]      rsp_sum_q;
  logic              rsp_cout_q;
  logic              rsp_of_q;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   rr_next;
  logic [N-1:0]      sel_a;
  logic [N-1:0]      sel_b;
  logic              sel_cin;
  logic              ovf;

  // Round-robin search: first pass covers [rr, REQ-1], second pass wraps to [0, rr-1].
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < int'(REQ); i++) begin
      if (!gnt_found && req_valid[i] && (ID_W'(i) >= rr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < int'(REQ); i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
  end

  // Operand and effective carry-in mux for the granted requester.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < int'(REQ); i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a   = req_a[i*N +: N];
        sel_b   = req_b[i*N +: N];
        sel_cin = req_chain[i] ? carry_q[i] : req_cin[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && gnt_found) begin
      req_ready = REQ'(1) << gnt_idx;
    end
  end

  assign rr_next = (gnt_idx == ID_W'(REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign ovf     = (a_q[N-1] == b_q[N-1]) && (add_sum[N-1] != a_q[N-1]);

  // Controller state, captured operands, per-requester carries and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      carry_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_of_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            cin_q   <= sel_cin;
            id_q    <= gnt_idx;
            rr_q    <= rr_next;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_q   <= add_sum;
          rsp_cout_q  <= add_cout;
          rsp_of_q    <= ovf;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          for (int i = 0; i < int'(REQ); i++) begin
            if (id_q == ID_W'(i)) begin
              carry_q[i] <= add_cout;
            end
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Adder inputs come straight from the capture registers, so they only move on accept.
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_of    = rsp_of_q;
  assign busy      = busy_q;

endmodule
